i2c_write_master: RTL
=====================

# i2c_write_master

Parametrised I2C write-transaction engine for the audio/video codec configuration path. It generalises the fixed 24-bit initialiser to a configurable byte count and SCL rate, with per-byte ACK checking, NACK byte reporting and optional automatic retry. It sits between the configuration sequencer, which presents one write transaction per `start` pulse, and the codec I2C pins.

## Interface
- `CLK_FREQ`, 50000000: input clock frequency in Hz.
- `I2C_FREQ`, 40000: target SCL frequency in Hz.
- `NUM_BYTES`, 3: bytes per transaction (slave address/RW + payload). Legal range 1..4.
- `MAX_RETRY`, 3: extra attempts after a NACK. Used only with `I2C_RETRY_EN`. Legal range 0..15.
- `i2c_clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a transaction. Sampled only while `busy`=0.
- `tx_data`  in  8*NUM_BYTES  transaction bytes, MSB byte sent first. Captured on the accepted `start`.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse when a transaction finishes.
- `ack_err`  out  1  the last transaction ended in a NACK. Valid from `done`; held until the next accepted `start`.
- `err_byte`  out  2  index (0 = first byte) of the NACKed byte. Valid when `ack_err`=1.
- `i2c_scl`  out  1  SCL, push-pull.
- `i2c_sda`  inout  1  SDA, open-drain: driven 0 or released to 'z'.

## Operation
- Quarter divider: `DIV = CLK_FREQ/(4*I2C_FREQ)`, truncated (312 at the defaults). `DIV < 2` is an elaboration error. A counter runs 0..DIV-1 while busy and produces one tick per wrap. Each SCL bit is four quarters, q0..q3.
- IDLE: SCL=1, SDA released.
  - `start`=1 while idle: capture `tx_data` into a hold register and the shift register, clear `ack_err`/`err_byte`, set `busy`, zero the counter and the retry count, then go to START.
- START: q0 SCL=1, SDA=1 | q1 SCL=1, SDA=0 | q2 SCL=1, SDA=0 | q3 SCL=0, SDA=0. Then DATA with byte 0.
- DATA: 8 bits, MSB first. Per bit: q0 SCL=0, SDA=bit | q1 SCL=1 | q2 SCL=1 | q3 SCL=0.
- ACK:
  - q0 SCL=0, SDA released | q1 SCL=1 | q2 SCL=1, sample `i2c_sda` | q3 SCL=0.
  - Sample 0: next byte to DATA, or STOP after the last byte.
  - Sample 1 (NACK): record the byte index in `err_byte`, set the internal nack flag, go to STOP. Remaining bytes are skipped.
- STOP: q0 SCL=0, SDA=0 | q1 SCL=1, SDA=0 | q2 SCL=1, SDA released | q3 SCL=1, SDA released.
  - End of STOP with nack set and a retry available: clear nack, increment the retry count, reload the shift register from the hold register, go to START.
  - Otherwise go to DONE.
- DONE: lasts one cycle. `done`=1, `busy`=0, `ack_err` = nack flag. Then IDLE.
- `start` while busy is ignored, with no queuing. `tx_data` changes while busy have no effect.

## Timing
- Reset values: `i2c_scl`=1, `i2c_sda`='z', `busy`=0, `done`=0, `ack_err`=0, `err_byte`=0, state IDLE.
- All outputs are registered. The SCL/SDA values of a quarter appear the cycle after the tick that enters it. The first quarter starts the cycle after `start` is accepted.
- Quarters per attempt: 8 + 36*NUM_BYTES (116 at the defaults).
  - `busy` is high for exactly (8+36*NUM_BYTES)*DIV cycles on an ACKed transaction.
  - `done` follows in the next cycle.
- NACK on byte k shortens an attempt to 8 + 36*(k+1) quarters.
- SDA changes only while SCL=0, except the START and STOP edges.
- Reset mid-transaction: SCL=1 and SDA released immediately. No STOP is generated, and no `done` pulse is issued.

## Configuration
- `I2C_RETRY_EN` defined: on NACK, up to MAX_RETRY repeated attempts (STOP, then a fresh START) with the original bytes.
  - `ack_err`=1 only if the final attempt NACKs. `err_byte` reports the final attempt.
  - A single `done` is issued at the end of all attempts.
- Undefined: no retry. The first NACK ends the transaction with `ack_err`=1. MAX_RETRY is ignored.

## Test plan
- Set CLK_FREQ=400000, I2C_FREQ=20000 (DIV=5), NUM_BYTES=3, `tx_data`=0x34_1E_00, slave model ACKs everything.
  - Required: SDA bit stream 0x34/A, 0x1E/A, 0x00/A between a START and a STOP.
  - `busy` high for 580 cycles, then `done` for 1 cycle, `ack_err`=0.
- Same setup, slave NACKs byte 1.
  - Without the macro: byte 2 is not sent, STOP is issued, `ack_err`=1, `err_byte`=1, `busy` high for 80*5 cycles.
- Build with `I2C_RETRY_EN`, MAX_RETRY=2, slave NACKs the first two attempts and ACKs the third.
  - Required: three STARTs, one `done`, `ack_err`=0.
  - Repeat with the slave always NACKing: three attempts, then `ack_err`=1.
- Pulse `start` again mid-transaction with different `tx_data`.
  - Required: it is ignored, the bus carries the original bytes, and exactly one `done` is issued.
- Assert `reset` during byte 1.
  - Required: next cycle `i2c_scl`=1, `i2c_sda`='z', `busy`=0, and no `done`.
  - A following `start` runs a clean full transaction.
- NUM_BYTES=1, `tx_data`=0xA5, ACK.
  - Required: 44 quarters, SDA 1-0-1-0-0-1-0-1, then an ACK slot and STOP.

Source files
------------

// File: rtl/i2c_write_master.sv
// I2C write-transaction engine: START, NUM_BYTES bytes with per-byte ACK check, STOP.
// Optional automatic retry on NACK when I2C_RETRY_EN is defined.
module i2c_write_master #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned I2C_FREQ  = 40000,
    parameter int unsigned NUM_BYTES = 3,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                   i2c_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] tx_data,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_err,
    output logic [1:0]             err_byte,
    output logic                   i2c_scl,
    inout  wire                    i2c_sda
);
    localparam int unsigned DIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned W   = 8 * NUM_BYTES;
`ifdef I2C_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    if (DIV < 2) begin : g_div_chk
        $error("i2c_write_master: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
    end
    if (NUM_BYTES < 1 || NUM_BYTES > 4) begin : g_nb_chk
        $error("i2c_write_master: NUM_BYTES must be 1..4");
    end
    if (MAX_RETRY > 15) begin : g_retry_chk
        $error("i2c_write_master: MAX_RETRY must be 0..15");
    end

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StAck   = 3'd3;
    localparam logic [2:0] StStop  = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  shift_q, shift_d, hold_q, hold_d;
    logic          nack_q, nack_d;
    logic [3:0]    retry_q, retry_d;
    logic          ack_err_d;
    logic [1:0]    err_byte_d;
    logic          scl_d, sda_oe_d, sda_oe_q, busy_d, done_d;
    logic          tick, retry_ok, active;

    assign tick     = (cnt_q == CW'(DIV - 1));
    assign retry_ok = RETRY_EN && (retry_q < 4'(MAX_RETRY));
    assign active   = (state_q != StIdle) && (state_q != StDone);

    always_comb begin
        state_d    = state_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        nack_d     = nack_q;
        retry_d    = retry_q;
        ack_err_d  = ack_err;
        err_byte_d = err_byte;
        if (active) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) qtr_d = qtr_q + 2'd1;
        end
        case (state_q)
            StIdle: begin
                if (start) begin
                    hold_d     = tx_data;
                    shift_d    = tx_data;
                    ack_err_d  = 1'b0;
                    err_byte_d = 2'd0;
                    nack_d     = 1'b0;
                    retry_d    = 4'd0;
                    cnt_d      = '0;
                    qtr_d      = 2'd0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (tick && qtr_q == 2'd3) begin
                    bit_d   = 3'd0;
                    byte_d  = 2'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (tick && qtr_q == 2'd3) begin
                    shift_d = shift_q << 1;
                    if (bit_q == 3'd7) state_d = StAck;
                    else bit_d = bit_q + 3'd1;
                end
            end
            StAck: begin
                // SCL is high during q2, so the slave's answer is stable here
                if (tick && qtr_q == 2'd2 && i2c_sda) begin
                    nack_d     = 1'b1;
                    err_byte_d = byte_q;
                end
                if (tick && qtr_q == 2'd3) begin
                    if (nack_q || byte_q == 2'(NUM_BYTES - 1)) begin
                        state_d = StStop;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        bit_d   = 3'd0;
                        state_d = StData;
                    end
                end
            end
            StStop: begin
                if (tick && qtr_q == 2'd3) begin
                    if (nack_q && retry_ok) begin
                        nack_d  = 1'b0;
                        retry_d = retry_q + 4'd1;
                        shift_d = hold_q;
                        state_d = StStart;
                    end else begin
                        ack_err_d = nack_q;
                        state_d   = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin levels are decoded from the next state so they register in step with it
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            StStart: begin
                scl_d    = (qtr_d != 2'd3);
                sda_oe_d = (qtr_d != 2'd0);
            end
            StData: begin
                scl_d    = qtr_d[0] ^ qtr_d[1];
                sda_oe_d = ~shift_d[W-1];
            end
            StAck:  scl_d = qtr_d[0] ^ qtr_d[1];
            StStop: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = ~qtr_d[1];
            end
            default: ;
        endcase
        busy_d = (state_d != StIdle) && (state_d != StDone);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge i2c_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            qtr_q    <= 2'd0;
            bit_q    <= 3'd0;
            byte_q   <= 2'd0;
            cnt_q    <= '0;
            shift_q  <= '0;
            hold_q   <= '0;
            nack_q   <= 1'b0;
            retry_q  <= 4'd0;
            ack_err  <= 1'b0;
            err_byte <= 2'd0;
            i2c_scl  <= 1'b1;
            sda_oe_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            hold_q   <= hold_d;
            nack_q   <= nack_d;
            retry_q  <= retry_d;
            ack_err  <= ack_err_d;
            err_byte <= err_byte_d;
            i2c_scl  <= scl_d;
            sda_oe_q <= sda_oe_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule
